// File: rtl/rx_bit_timing_ctrl.sv
// -----------------------------------------------------------------------------
// rx_bit_timing_ctrl
//
// Bit-timing controller for a serial receiver. After the start-bit detector
// pulses, it counts CLKS_PER_BIT clocks per bit. It strobes the data shift
// register once per data bit. It samples the stop bit and then tells the
// receive buffer to load, or flags a framing error.
//
// Frame timeline (cycle 0 = the cycle after the edge that accepts the start):
//   strobe k (k = 1..DATA_BITS+1) occurs in cycle k*CLKS_PER_BIT
//   strobes 1..DATA_BITS       -> shift_enable high for that one cycle
//   strobe DATA_BITS+1         -> serial_in registered as the stop bit
//   next cycle (STOP_CHK)      -> stop bit 1: LOAD, stop bit 0: framing error
//   LOAD                       -> load_buffer high for one cycle, back to IDLE
//
// Parameters:
//   CLKS_PER_BIT       clock cycles per serial bit (4..255)
//   DATA_BITS          data bits per frame, LSB first (1..15)
//
// Ports:
//   clk                system clock, rising-edge active
//   n_rst              asynchronous active-low reset
//   start_bit_detected one-cycle start-bit pulse, honoured only in IDLE
//   serial_in          synchronized serial line (idle high)
//   shift_enable       one-cycle strobe per data bit
//   load_buffer        one-cycle pulse to capture the parallel data
//   framing_error      sticky flag, set when the stop bit is sampled low
//   busy               high while a frame is being timed
// -----------------------------------------------------------------------------
module rx_bit_timing_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic start_bit_detected,
    input  logic serial_in,
    output logic shift_enable,
    output logic load_buffer,
    output logic framing_error,
    output logic busy
);

    // The counters are sized for the largest legal parameters:
    // clk_cnt reaches 254, and bit_cnt reaches 16 (DATA_BITS+1).
    localparam logic [7:0] CNT_MAX  = 8'(CLKS_PER_BIT - 1);
    localparam logic [4:0] DATA_IDX = 5'(DATA_BITS);
    localparam logic [4:0] STOP_IDX = 5'(DATA_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOP_CHK = 2'd2,
        ST_LOAD     = 2'd3
    } state_t;

    state_t     state_r;
    logic [7:0] clk_cnt_r;
    logic [4:0] bit_cnt_r;
    logic       stop_bit_r;
    logic       shift_enable_r;
    logic       load_buffer_r;
    logic       framing_error_r;
    logic       busy_r;

    // Frame FSM, bit/clock counters and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r         <= ST_IDLE;
            clk_cnt_r       <= 8'd0;
            bit_cnt_r       <= 5'd0;
            stop_bit_r      <= 1'b0;
            shift_enable_r  <= 1'b0;
            load_buffer_r   <= 1'b0;
            framing_error_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            // Strobes default low, so each one lasts exactly one cycle.
            shift_enable_r <= 1'b0;
            load_buffer_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_bit_detected) begin
                        state_r         <= ST_RUN;
                        clk_cnt_r       <= 8'd0;
                        bit_cnt_r       <= 5'd0;
                        framing_error_r <= 1'b0;
                        busy_r          <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // bit_cnt_r == STOP_IDX marks the stop-bit strobe cycle.
                    // serial_in is captured on the edge that ends that cycle.
                    if (bit_cnt_r == STOP_IDX) begin
                        stop_bit_r <= serial_in;
                        state_r    <= ST_STOP_CHK;
                    end else if (clk_cnt_r == CNT_MAX) begin
                        // This wrap starts strobe bit_cnt_r+1. Only the
                        // data-bit strobes drive the shift register.
                        clk_cnt_r      <= 8'd0;
                        bit_cnt_r      <= bit_cnt_r + 5'd1;
                        shift_enable_r <= (bit_cnt_r < DATA_IDX);
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 8'd1;
                    end
                end
                ST_STOP_CHK: begin
                    if (stop_bit_r) begin
                        state_r       <= ST_LOAD;
                        load_buffer_r <= 1'b1;
                    end else begin
                        framing_error_r <= 1'b1;
                        state_r         <= ST_IDLE;
                        busy_r          <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    clk_cnt_r <= 8'd0;
                    bit_cnt_r <= 5'd0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign shift_enable  = shift_enable_r;
    assign load_buffer   = load_buffer_r;
    assign framing_error = framing_error_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_rx_bit_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_bit_timing_ctrl
//
// Scoreboard bench. Instance 0 uses the default parameters (10, 8).
// Instance 1 uses (4, 15), and instance 2 uses (255, 1).
//
// Whenever a start pulse is issued, the stimulus pushes every expected output
// event into that instance's queue. Each event has a kind and an absolute
// cycle. The negedge monitor detects the events on the outputs, pops the
// queues and compares them against the expected events.
// -----------------------------------------------------------------------------
module tb_rx_bit_timing_ctrl;

    localparam int EV_BUSY_RISE = 0;
    localparam int EV_FERR_FALL = 1;
    localparam int EV_SHIFT     = 2;
    localparam int EV_LOAD      = 3;
    localparam int EV_FERR_RISE = 4;
    localparam int EV_BUSY_FALL = 5;

    typedef struct packed {
        int kind;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [2:0] sbd = 3'b000;
    logic       serial_in = 1'b1;
    logic [2:0] se, lb, fe, bz;
    logic [2:0] bz_p = 3'b000;
    logic [2:0] fe_p = 3'b000;
    bit   [2:0] ferr_m = 3'b000;
    bit         mon_en = 1'b0;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    ev_t        q0[$];
    ev_t        q1[$];
    ev_t        q2[$];

    rx_bit_timing_ctrl #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut0 (
        .clk(clk), .n_rst(n_rst), .start_bit_detected(sbd[0]), .serial_in(serial_in),
        .shift_enable(se[0]), .load_buffer(lb[0]), .framing_error(fe[0]), .busy(bz[0]));

    rx_bit_timing_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(15)) dut1 (
        .clk(clk), .n_rst(n_rst), .start_bit_detected(sbd[1]), .serial_in(serial_in),
        .shift_enable(se[1]), .load_buffer(lb[1]), .framing_error(fe[1]), .busy(bz[1]));

    rx_bit_timing_ctrl #(.CLKS_PER_BIT(255), .DATA_BITS(1)) dut2 (
        .clk(clk), .n_rst(n_rst), .start_bit_detected(sbd[2]), .serial_in(serial_in),
        .shift_enable(se[2]), .load_buffer(lb[2]), .framing_error(fe[2]), .busy(bz[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int idx, input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic observe(input int idx, input int kind);
        ev_t e;
        bit  empty;
        e = '{kind: -1, cyc: -1};
        case (idx)
            0:       begin empty = (q0.size() == 0); if (!empty) e = q0.pop_front(); end
            1:       begin empty = (q1.size() == 0); if (!empty) e = q1.pop_front(); end
            default: begin empty = (q2.size() == 0); if (!empty) e = q2.pop_front(); end
        endcase
        tests++;
        if (empty) begin
            fails++;
            $display("FAIL unexpected_event dut%0d: got kind %0d at cycle %0d, required none", idx, kind, cyc);
        end else if (e.kind != kind || e.cyc != cyc) begin
            fails++;
            $display("FAIL event dut%0d: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                     idx, kind, cyc, e.kind, e.cyc);
        end
    endtask

    task automatic chk(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    // The monitor turns output edges and strobes into events, in a fixed order within a cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                if (bz[i] && !bz_p[i]) observe(i, EV_BUSY_RISE);
                if (!fe[i] && fe_p[i]) observe(i, EV_FERR_FALL);
                if (se[i])             observe(i, EV_SHIFT);
                if (lb[i])             observe(i, EV_LOAD);
                if (fe[i] && !fe_p[i]) observe(i, EV_FERR_RISE);
                if (!bz[i] && bz_p[i]) observe(i, EV_BUSY_FALL);
            end
        end
        bz_p <= bz;
        fe_p <= fe;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue a start pulse (called at a negedge) and queue the full expected
    // response. Return in the first cycle after the frame ends.
    task automatic frame(input int idx, input int c, input int d, input bit stop_ok, input bit extras);
        int s;
        int stop_c;
        s      = cyc + 1;
        stop_c = (d + 1) * c;
        sbd[idx] = 1'b1;
        push(idx, EV_BUSY_RISE, s);
        if (ferr_m[idx]) push(idx, EV_FERR_FALL, s);
        for (int k = 1; k <= d; k++) push(idx, EV_SHIFT, s + k * c);
        if (stop_ok) begin
            push(idx, EV_LOAD, s + stop_c + 2);
            push(idx, EV_BUSY_FALL, s + stop_c + 3);
        end else begin
            push(idx, EV_FERR_RISE, s + stop_c + 2);
            push(idx, EV_BUSY_FALL, s + stop_c + 2);
        end
        ferr_m[idx] = !stop_ok;
        @(negedge clk);
        while (cyc < s + stop_c + 3) begin
            sbd[idx]  = extras && (cyc == s + 5 || cyc == s + 45 || cyc == s + stop_c || cyc == s + stop_c + 2);
            serial_in = (cyc == s + stop_c) ? stop_ok : 1'b1;
            @(negedge clk);
        end
        sbd[idx]  = 1'b0;
        serial_in = 1'b1;
    endtask

    initial begin
        int s;
        // Check the state under reset.
        idle(3);
        chk("reset_shift_enable", se[0], 1'b0);
        chk("reset_load_buffer", lb[0], 1'b0);
        chk("reset_framing_error", fe[0], 1'b0);
        chk("reset_busy", bz[0], 1'b0);
        mon_en = 1'b1;
        n_rst  = 1'b1;
        idle(5);

        // Valid frame, bad stop bit, then a valid frame with ignored extra starts.
        frame(0, 10, 8, 1'b1, 1'b0);
        idle(10);
        frame(0, 10, 8, 1'b0, 1'b0);
        idle(10);
        chk("framing_error_sticky", fe[0], 1'b1);
        frame(0, 10, 8, 1'b1, 1'b1);
        idle(5);

        // Reset in cycle 47 of a frame.
        sbd[0] = 1'b1;
        s = cyc + 1;
        push(0, EV_BUSY_RISE, s);
        for (int k = 1; k <= 4; k++) push(0, EV_SHIFT, s + k * 10);
        push(0, EV_BUSY_FALL, s + 47);
        @(negedge clk);
        sbd[0] = 1'b0;
        do begin
            @(posedge clk);
            #1;
        end while (cyc < s + 47);
        n_rst = 1'b0;
        #1;
        chk("midreset_shift_enable", se[0], 1'b0);
        chk("midreset_load_buffer", lb[0], 1'b0);
        chk("midreset_framing_error", fe[0], 1'b0);
        chk("midreset_busy", bz[0], 1'b0);
        idle(3);
        n_rst = 1'b1;
        idle(150);
        frame(0, 10, 8, 1'b1, 1'b0);
        idle(5);

        // Back-to-back frames: the second start comes in the first cycle after LOAD.
        frame(0, 10, 8, 1'b1, 1'b0);
        frame(0, 10, 8, 1'b1, 1'b0);
        idle(5);

        // Parameter extremes.
        frame(1, 4, 15, 1'b1, 1'b0);
        idle(5);
        frame(1, 4, 15, 1'b0, 1'b0);
        idle(5);
        frame(2, 255, 1, 1'b1, 1'b0);
        idle(5);
        frame(1, 4, 15, 1'b1, 1'b0);
        idle(5);
        frame(2, 255, 1, 1'b0, 1'b0);
        idle(10);

        // Every expected event must have been consumed.
        tests++;
        if (q0.size() != 0) begin fails++; $display("FAIL leftover_dut0: got %0d pending, required 0", q0.size()); end
        tests++;
        if (q1.size() != 0) begin fails++; $display("FAIL leftover_dut1: got %0d pending, required 0", q1.size()); end
        tests++;
        if (q2.size() != 0) begin fails++; $display("FAIL leftover_dut2: got %0d pending, required 0", q2.size()); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
